// File: rtl/cherry_dma_pkg.sv
// Shared DMA instruction definitions used by the instruction queue, top and dma_uart.
// Instruction layout: [21] valid, [20] write(1)/read(0), [19:0] opaque payload.
package cherry_dma_pkg;

  localparam int DMA_INSTR_W   = 22;
  localparam int DMA_VALID_BIT = 21;
  localparam int DMA_WRITE_BIT = 20;

  typedef logic [DMA_INSTR_W-1:0] dma_instr_t;

  function automatic logic instr_is_valid(input dma_instr_t instr);
    return instr[DMA_VALID_BIT];
  endfunction

endpackage

// File: rtl/dma_queue_mem.sv
// Instruction storage for the DMA queue: one synchronous write port and one
// asynchronous read port. The array is deliberately left unreset.
module dma_queue_mem
  import cherry_dma_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = DMA_INSTR_W
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store an accepted instruction at the write pointer
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dma_instr_queue.sv
// First-word-fall-through DMA instruction queue feeding dma_uart. The head entry
// is always presented on dma_instr, forced to zero when empty so its valid bit is clear.
module dma_instr_queue
  import cherry_dma_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = DMA_INSTR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       instr_in,
  input  logic                   we,
  output logic                   full,
  output logic [WIDTH-1:0]       dma_instr,
  input  logic                   re,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_next;
  logic             overflow_q;
  logic             pop;
  logic             wr_accept;
  logic             wr_drop;
  logic             instr_valid;
  logic [WIDTH-1:0] head;

  assign instr_valid = instr_is_valid(instr_in);

  // Flags derive only from registered occupancy, never from we/re
  assign empty    = (count_q == {CW{1'b0}});
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign overflow = overflow_q;

  // Pop/accept decisions; a full queue still accepts when it pops in the same cycle
  always_comb begin
    pop       = 1'b0;
    wr_accept = 1'b0;
    wr_drop   = 1'b0;
    if (re && !empty) begin
      pop = 1'b1;
    end else begin
      pop = 1'b0;
    end
    if (we && instr_valid) begin
      wr_accept = !full || pop;
      wr_drop   = full && !pop;
    end else begin
      wr_accept = 1'b0;
      wr_drop   = 1'b0;
    end
  end

  // Occupancy update: + accepted write, - pop
  always_comb begin
    count_next = count_q;
    case ({wr_accept, pop})
      2'b10:   count_next = count_q + CW'(1);
      2'b01:   count_next = count_q - CW'(1);
      default: count_next = count_q;
    endcase
  end

  // Pointers, occupancy and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= {AW{1'b0}};
      wr_ptr     <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr_accept) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (wr_drop) begin
        overflow_q <= 1'b1;
      end
      count_q <= count_next;
    end
  end

  dma_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr),
    .wr_data (instr_in),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  // Zero the head when empty so stale storage never looks like a valid instruction
  always_comb begin
    dma_instr = {WIDTH{1'b0}};
    if (empty) begin
      dma_instr = {WIDTH{1'b0}};
    end else begin
      dma_instr = head;
    end
  end

endmodule
